// File: rtl/sys_array_pkg.sv
// Shared types and the width-generic saturating adder used by the systolic PE.
package sys_array_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Widest accumulator the adder supports; callers sign-extend into this width.
  localparam int SAT_MAXW = 64;
  localparam logic signed [SAT_MAXW:0] SAT_ONE = (SAT_MAXW + 1)'(1);

  // Returns {sum, ovf}; truncating the result to width+1 bits leaves {sum[width-1:0], ovf}.
  function automatic logic [SAT_MAXW:0] sat_add(
    input logic signed [SAT_MAXW-1:0] a,
    input logic signed [SAT_MAXW-1:0] b,
    input int                         width,
    input logic                       saturate
  );
    logic signed [SAT_MAXW:0] s;
    logic signed [SAT_MAXW:0] hi;
    logic signed [SAT_MAXW:0] lo;
    logic signed [SAT_MAXW:0] wrapped;
    logic signed [SAT_MAXW:0] res;
    logic                     ovf;
    s       = {a[SAT_MAXW-1], a} + {b[SAT_MAXW-1], b};
    hi      = (SAT_ONE <<< (width - 1)) - SAT_ONE;
    lo      = -(SAT_ONE <<< (width - 1));
    wrapped = (s <<< (SAT_MAXW + 1 - width)) >>> (SAT_MAXW + 1 - width);
    ovf     = (s > hi) || (s < lo);
    if (!ovf) begin
      res = s;
    end else if (saturate) begin
      res = (s > hi) ? hi : lo;
    end else begin
      res = wrapped;
    end
    return {SAT_MAXW'(res), ovf};
  endfunction

endpackage

// File: rtl/sys_array_pe_mul.sv
// Signed multiplier with an optional output register; the valid bit travels with the product.
module sys_array_pe_mul #(
  parameter int DATA_WIDTH = 8,
  parameter int MUL_PIPE   = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic signed [DATA_WIDTH-1:0]   a_i,
  input  logic signed [DATA_WIDTH-1:0]   b_i,
  input  logic                           valid_i,
  output logic signed [2*DATA_WIDTH-1:0] prod_o,
  output logic                           valid_o
);

  logic signed [2*DATA_WIDTH-1:0] prod_d;
  logic signed [2*DATA_WIDTH-1:0] prod_q;
  logic                           valid_q;

  assign prod_d = a_i * b_i;

  // With MUL_PIPE=0 the register below has no loads and is trimmed away.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      valid_q <= valid_i;
    end
  end

  assign prod_o  = (MUL_PIPE != 0) ? prod_q : prod_d;
  assign valid_o = (MUL_PIPE != 0) ? valid_q : valid_i;

endmodule

// File: rtl/sys_array_pe.sv
// Systolic PE: weight-stationary psum chain or output-stationary accumulate with counted drain.
module sys_array_pe
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int MUL_PIPE   = 0,
  parameter int SATURATE   = 1,
  parameter int ROW_IDX    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mode,
  input  logic                  param_load,
  input  logic [DATA_WIDTH-1:0] param_in,
  output logic [DATA_WIDTH-1:0] param_out,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  fwd_valid,
  output logic [DATA_WIDTH-1:0] fwd_data,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  psum_in_valid,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  psum_out_valid,
  input  logic                  drain,
  output logic                  busy,
  output logic                  overflow
);

  localparam int CNT_W  = (ROW_IDX > 0) ? $clog2(ROW_IDX + 1) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int RES_W  = ACC_WIDTH + 1;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] par_q, par_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]         psum_out_q, psum_out_d;
  logic                         psum_out_valid_q, psum_out_valid_d;
  logic                         overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]        param_out_q;
  logic [DATA_WIDTH-1:0]        fwd_data_q;
  logic                         fwd_valid_q;

  logic                         is_ws;
  logic                         mul_valid_in;
  logic signed [DATA_WIDTH-1:0] mul_op;
  logic signed [PROD_W-1:0]     prod;
  logic                         prod_valid;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  ws_base;
  logic [RES_W-1:0]             ws_res;   // {sum, ovf}
  logic [RES_W-1:0]             acc_res;  // {sum, ovf}

  assign is_ws        = (mode == MODE_WS);
  assign mul_op       = is_ws ? par_q : $signed(param_in);
  assign mul_valid_in = in_valid && !(is_ws && param_load);

  sys_array_pe_mul #(
    .DATA_WIDTH(DATA_WIDTH),
    .MUL_PIPE  (MUL_PIPE)
  ) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .a_i    (in_data),
    .b_i    (mul_op),
    .valid_i(mul_valid_in),
    .prod_o (prod),
    .valid_o(prod_valid)
  );

  assign prod_ext = ACC_WIDTH'(prod);
  assign ws_base  = psum_in_valid ? $signed(psum_in) : '0;
  assign ws_res   = RES_W'(sat_add(SAT_MAXW'(ws_base), SAT_MAXW'(prod_ext), ACC_WIDTH, SATURATE != 0));
  assign acc_res  = RES_W'(sat_add(SAT_MAXW'(acc_q), SAT_MAXW'(prod_ext), ACC_WIDTH, SATURATE != 0));

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    par_d            = par_q;
    acc_d            = acc_q;
    psum_out_d       = psum_out_q;
    psum_out_valid_d = 1'b0;
    overflow_d       = overflow_q;
    if (state_q == ST_DRAIN) begin
      // Compute keeps running into the freshly cleared accumulator while upstream words pass.
      if (prod_valid) begin
        acc_d      = acc_res[RES_W-1:1];
        overflow_d = overflow_q | acc_res[0];
      end
      if (psum_in_valid) begin
        psum_out_d       = psum_in;
        psum_out_valid_d = 1'b1;
        cnt_d            = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
    end else if (is_ws) begin
      if (param_load) begin
        par_d = param_in;
      end
      if (!(param_load && MUL_PIPE == 0)) begin
        if (prod_valid) begin
          psum_out_d       = ws_res[RES_W-1:1];
          psum_out_valid_d = 1'b1;
          overflow_d       = overflow_q | ws_res[0];
        end else if (psum_in_valid) begin
          psum_out_d       = psum_in;
          psum_out_valid_d = 1'b1;
        end
      end
    end else begin
      if (drain) begin
        psum_out_d       = prod_valid ? acc_res[RES_W-1:1] : acc_q;
        psum_out_valid_d = 1'b1;
        acc_d            = '0;
        overflow_d       = 1'b0;
        cnt_d            = CNT_W'(ROW_IDX);
        state_d          = (ROW_IDX > 0) ? ST_DRAIN : ST_RUN;
      end else if (prod_valid) begin
        acc_d      = acc_res[RES_W-1:1];
        overflow_d = overflow_q | acc_res[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= ST_RUN;
      cnt_q            <= '0;
      par_q            <= '0;
      acc_q            <= '0;
      psum_out_q       <= '0;
      psum_out_valid_q <= 1'b0;
      overflow_q       <= 1'b0;
      param_out_q      <= '0;
      fwd_data_q       <= '0;
      fwd_valid_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      par_q            <= par_d;
      acc_q            <= acc_d;
      psum_out_q       <= psum_out_d;
      psum_out_valid_q <= psum_out_valid_d;
      overflow_q       <= overflow_d;
      param_out_q      <= param_in;
      fwd_data_q       <= in_data;
      fwd_valid_q      <= in_valid;
    end
  end

  assign param_out      = param_out_q;
  assign fwd_data       = fwd_data_q;
  assign fwd_valid      = fwd_valid_q;
  assign psum_out       = psum_out_q;
  assign psum_out_valid = psum_out_valid_q;
  assign busy           = (state_q == ST_DRAIN);
  assign overflow       = overflow_q;

endmodule
